// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 UART receiver feeding a show-ahead receive FIFO.
// Optional build macro UART_RECEIVER_MAJORITY_EN: 2-of-3 majority sampling at sub-ticks 7, 8, 9.
module uart_receiver #(
   parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
   parameter int unsigned FIFO_DEPTH      = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       data_in,
   input  logic [1:0] baudrate_select,
   input  logic       read_enable,
   output logic [7:0] data_out,
   output logic       buffer_empty,
   output logic       frame_error,
   output logic       overrun_error
);
   localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW   = PtrW + 1;
   localparam int unsigned DivMax = CLOCK_FREQUENCY / (9600 * 16);
   localparam int unsigned DivW   = $clog2(DivMax + 1);

   localparam logic [DivW-1:0] Div9600   = DivW'(CLOCK_FREQUENCY / (9600 * 16));
   localparam logic [DivW-1:0] Div19200  = DivW'(CLOCK_FREQUENCY / (19200 * 16));
   localparam logic [DivW-1:0] Div57600  = DivW'(CLOCK_FREQUENCY / (57600 * 16));
   localparam logic [DivW-1:0] Div115200 = DivW'(CLOCK_FREQUENCY / (115200 * 16));

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q;
   logic [1:0]      sync_q;
   logic            line_prev_q;
   logic [1:0]      baud_q;
   logic [DivW-1:0] tick_cnt_q;
   logic [3:0]      sub_cnt_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;
   logic            frame_error_q;
   logic            overrun_error_q;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] count_q;

   logic            line;
   logic            fall;
   logic            tick;
   logic            decide;
   logic            sample_bit;
   logic [DivW-1:0] divisor;
   logic            full;
   logic            pop;
   logic            push;

   assign line = sync_q[1];
   assign fall = line_prev_q & ~line;

   always_comb begin
      divisor = Div115200;
      unique case (baud_q)
         2'b00: divisor = Div9600;
         2'b01: divisor = Div19200;
         2'b10: divisor = Div57600;
         2'b11: divisor = Div115200;
      endcase
   end

   assign tick = (state_q != StIdle) && (tick_cnt_q == divisor - DivW'(1));

`ifdef UART_RECEIVER_MAJORITY_EN
   logic s7_q;
   logic s8_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s7_q <= 1'b1;
         s8_q <= 1'b1;
      end else begin
         if (tick && sub_cnt_q == 4'd6) s7_q <= line;
         if (tick && sub_cnt_q == 4'd7) s8_q <= line;
      end
   end

   assign decide     = tick && (sub_cnt_q == 4'd8);
   assign sample_bit = (s7_q & s8_q) | (s7_q & line) | (s8_q & line);
`else
   assign decide     = tick && (sub_cnt_q == 4'd7);
   assign sample_bit = line;
`endif

   assign full = (count_q == CntW'(FIFO_DEPTH));
   assign pop  = read_enable && (count_q != '0);
   // A full FIFO still accepts the byte when the host pops in the same cycle.
   assign push = (state_q == StStop) && decide && sample_bit && (!full || pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= StIdle;
         sync_q          <= 2'b11;
         line_prev_q     <= 1'b1;
         baud_q          <= 2'b00;
         tick_cnt_q      <= '0;
         sub_cnt_q       <= '0;
         bit_idx_q       <= '0;
         shift_q         <= '0;
         frame_error_q   <= 1'b0;
         overrun_error_q <= 1'b0;
      end else begin
         sync_q          <= {sync_q[0], data_in};
         line_prev_q     <= line;
         frame_error_q   <= 1'b0;
         overrun_error_q <= 1'b0;

         if (state_q == StIdle || tick) tick_cnt_q <= '0;
         else                           tick_cnt_q <= tick_cnt_q + DivW'(1);
         if (tick) sub_cnt_q <= sub_cnt_q + 4'd1;

         case (state_q)
            StIdle: begin
               // Edge-triggered start, so a held-low break cannot retrigger.
               if (fall) begin
                  state_q   <= StStart;
                  sub_cnt_q <= '0;
                  baud_q    <= baudrate_select;
               end
            end
            StStart: begin
               if (decide) begin
                  state_q   <= sample_bit ? StIdle : StData;
                  bit_idx_q <= '0;
               end
            end
            StData: begin
               if (decide) begin
                  shift_q[bit_idx_q] <= sample_bit;
                  bit_idx_q          <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) state_q <= StStop;
               end
            end
            StStop: begin
               if (decide) begin
                  state_q <= StIdle;
                  if (!sample_bit)       frame_error_q   <= 1'b1;
                  else if (full && !pop) overrun_error_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop)      count_q <= count_q + CntW'(1);
         else if (pop && !push) count_q <= count_q - CntW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= shift_q;
   end

   assign buffer_empty  = (count_q == '0);
   assign data_out      = buffer_empty ? 8'h00 : mem_q[rd_ptr_q];
   assign frame_error   = frame_error_q;
   assign overrun_error = overrun_error_q;

endmodule
